hazard_fwd_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 70 +++++++
 rtl/hazard_fwd_sel.sv | 50 +++++
 rtl/hazard_fwd_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings, stage record types and the E-stage selector helper
// for the hazard/forwarding controller.
package hazard_pkg;

    localparam int RF_AW  = 5;
    localparam int TNEW_W = 2;

    // Result source of an in-flight instruction
    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_PC8 = 2'd2;

    // Tuse value meaning "operand not read"
    localparam logic [TNEW_W-1:0] TUSE_NONE = 2'd3;

    // D-stage operand mux selects
    localparam logic [2:0] FWD_D_RF    = 3'd0;
    localparam logic [2:0] FWD_D_PC8_E = 3'd1;
    localparam logic [2:0] FWD_D_AO_M  = 3'd2;
    localparam logic [2:0] FWD_D_PC8_M = 3'd3;
    localparam logic [2:0] FWD_D_WD_W  = 3'd4;

    // E-stage operand mux selects
    localparam logic [1:0] FWD_E_RF    = 2'd0;
    localparam logic [1:0] FWD_E_AO_M  = 2'd1;
    localparam logic [1:0] FWD_E_PC8_M = 2'd2;
    localparam logic [1:0] FWD_E_WD_W  = 2'd3;

    // Shadow records; an all-zero record is a bubble
    typedef struct packed {
        logic [RF_AW-1:0]  rs;
        logic [RF_AW-1:0]  rt;
        logic [RF_AW-1:0]  a3;
        logic [TNEW_W-1:0] tnew;
        logic [1:0]        src;
    } e_rec_t;

    typedef struct packed {
        logic [RF_AW-1:0]  rt;
        logic [RF_AW-1:0]  a3;
        logic [TNEW_W-1:0] tnew;
        logic [1:0]        src;
    } m_rec_t;

    typedef struct packed {
        logic [RF_AW-1:0] a3;
        logic [1:0]       src;
    } w_rec_t;

    // E-stage operand select: M is younger than W, so it is checked first.
    // A MEM result in M is not yet available, so the register value is kept.
    function automatic logic [1:0] fwd_e_sel(input logic [RF_AW-1:0] r,
                                             input m_rec_t m,
                                             input w_rec_t w);
        logic [1:0] sel;
        sel = FWD_E_RF;
        if (r != '0 && m.a3 == r) begin
            if (m.src == SRC_PC8)
                sel = FWD_E_PC8_M;
            else if (m.src == SRC_ALU)
                sel = FWD_E_AO_M;
            else
                sel = FWD_E_RF;
        end else if (r != '0 && w.a3 == r) begin
            sel = FWD_E_WD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand D-stage selector: decides the D forwarding code and whether
// this operand forces a stall, from the E/M/W shadow records.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [RF_AW-1:0]  reg_idx,
    input  logic [TNEW_W-1:0] tuse,
    input  logic [RF_AW-1:0]  e_a3,
    input  logic [TNEW_W-1:0] e_tnew,
    input  logic [1:0]        e_src,
    input  logic [RF_AW-1:0]  m_a3,
    input  logic [TNEW_W-1:0] m_tnew,
    input  logic [1:0]        m_src,
    input  logic [RF_AW-1:0]  w_a3,
    output logic [2:0]        d_op,
    output logic              stall
);

    logic e_hit;
    logic m_hit;
    logic w_hit;

    // Register 0 is hard-wired, so it never matches a producer
    assign e_hit = (reg_idx != '0) && (e_a3 == reg_idx);
    assign m_hit = (reg_idx != '0) && (m_a3 == reg_idx);
    assign w_hit = (reg_idx != '0) && (w_a3 == reg_idx);

    // Stall when a producer's result arrives later than this operand is needed;
    // forward from the youngest matching stage only
    always_comb begin
        stall = 1'b0;
        d_op  = FWD_D_RF;
        if (tuse != TUSE_NONE) begin
            stall = (e_hit && (e_tnew > tuse)) || (m_hit && (m_tnew > tuse));
        end
        if (e_hit) begin
            d_op = (e_src == SRC_PC8) ? FWD_D_PC8_E : FWD_D_RF;
        end else if (m_hit) begin
            if (m_src == SRC_PC8)
                d_op = FWD_D_PC8_M;
            else if (m_src == SRC_ALU)
                d_op = FWD_D_AO_M;
            else
                d_op = FWD_D_RF;
        end else if (w_hit) begin
            d_op = FWD_D_WD_W;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline. Tracks E/M/W
// shadow records and produces the D-stage stall plus D/E/M mux selects.
// Optional macro HAZARD_STATS_EN adds stall_cnt/fwd_cnt statistics outputs.
module hazard_fwd_ctrl
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [RF_AW-1:0]  d_rs,
    input  logic [RF_AW-1:0]  d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [RF_AW-1:0]  d_a3,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic [1:0]        d_src,
    output logic              stall,
    output logic [2:0]        rsd_op,
    output logic [2:0]        rtd_op,
    output logic [1:0]        rse_op,
    output logic [1:0]        rte_op,
    output logic              rtm_op
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    e_rec_t e_rec_reg, e_rec_next;
    m_rec_t m_rec_reg, m_rec_next;
    w_rec_t w_rec_reg, w_rec_next;

    logic [RF_AW-1:0]  op_idx  [2];
    logic [TNEW_W-1:0] op_tuse [2];
    logic [2:0]        op_d_sel[2];
    logic              op_stall[2];

    assign op_idx[0]  = d_rs;
    assign op_idx[1]  = d_rt;
    assign op_tuse[0] = d_tuse_rs;
    assign op_tuse[1] = d_tuse_rt;

    // One selector per D-stage source operand (0 = rs, 1 = rt)
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_op
            hazard_fwd_sel u_sel (
                .reg_idx (op_idx[gi]),
                .tuse    (op_tuse[gi]),
                .e_a3    (e_rec_reg.a3),
                .e_tnew  (e_rec_reg.tnew),
                .e_src   (e_rec_reg.src),
                .m_a3    (m_rec_reg.a3),
                .m_tnew  (m_rec_reg.tnew),
                .m_src   (m_rec_reg.src),
                .w_a3    (w_rec_reg.a3),
                .d_op    (op_d_sel[gi]),
                .stall   (op_stall[gi])
            );
        end
    endgenerate

    assign stall  = op_stall[0] | op_stall[1];
    assign rsd_op = op_d_sel[0];
    assign rtd_op = op_d_sel[1];
    assign rse_op = fwd_e_sel(e_rec_reg.rs, m_rec_reg, w_rec_reg);
    assign rte_op = fwd_e_sel(e_rec_reg.rt, m_rec_reg, w_rec_reg);
    assign rtm_op = (m_rec_reg.rt != '0) && (w_rec_reg.a3 == m_rec_reg.rt);

    // Next records: bubble into E on stall; M and W always advance
    always_comb begin
        e_rec_next = '0;
        if (!stall) begin
            e_rec_next = '{rs: d_rs, rt: d_rt, a3: d_a3, tnew: d_tnew, src: d_src};
        end
        m_rec_next.rt   = e_rec_reg.rt;
        m_rec_next.a3   = e_rec_reg.a3;
        m_rec_next.src  = e_rec_reg.src;
        m_rec_next.tnew = (e_rec_reg.tnew == '0) ? '0 : e_rec_reg.tnew - 2'd1;
        w_rec_next.a3   = m_rec_reg.a3;
        w_rec_next.src  = m_rec_reg.src;
    end

    // Shadow pipeline registers, cleared to bubbles on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            e_rec_reg <= '0;
            m_rec_reg <= '0;
            w_rec_reg <= '0;
        end else begin
            e_rec_reg <= e_rec_next;
            m_rec_reg <= m_rec_next;
            w_rec_reg <= w_rec_next;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] fwd_cnt_reg;
    logic        any_fwd;

    assign any_fwd = (rsd_op != '0) || (rtd_op != '0) || (rse_op != '0) ||
                     (rte_op != '0) || rtm_op;

    // Free-running wrap-around event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            fwd_cnt_reg   <= '0;
        end else begin
            if (stall)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (any_fwd)
                fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign fwd_cnt   = fwd_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: each step drives one D-stage
// instruction, queues the expected outputs and checks them mid-cycle.
module tb_hazard_fwd_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_src;
    logic       stall;
    logic [2:0] rsd_op, rtd_op;
    logic [1:0] rse_op, rte_op;
    logic       rtm_op;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
    logic [31:0] exp_stall_cnt, exp_fwd_cnt;
`endif

    int total;
    int bad;
    int txn;

    typedef struct {
        logic       stall;
        logic [2:0] rsd;
        logic [2:0] rtd;
        logic [1:0] rse;
        logic [1:0] rte;
        logic       rtm;
    } exp_t;

    exp_t exp_q[$];

    hazard_fwd_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_a3      (d_a3),
        .d_tnew    (d_tnew),
        .d_src     (d_src),
        .stall     (stall),
        .rsd_op    (rsd_op),
        .rtd_op    (rtd_op),
        .rse_op    (rse_op),
        .rte_op    (rte_op),
        .rtm_op    (rtm_op)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s (txn %0d): observed=%0h expected=%0h", tag, txn, obs, expv);
        end
    endtask

    // Drive one D instruction, push its expected outputs, compare at negedge,
    // then advance to just after the next rising edge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                        input logic [4:0] a3, input logic [1:0] tnew, input logic [1:0] src,
                        input logic x_stall, input logic [2:0] x_rsd, input logic [2:0] x_rtd,
                        input logic [1:0] x_rse, input logic [1:0] x_rte, input logic x_rtm);
        exp_t e;
        d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt;
        d_a3 = a3; d_tnew = tnew; d_src = src;
        e.stall = x_stall; e.rsd = x_rsd; e.rtd = x_rtd;
        e.rse = x_rse; e.rte = x_rte; e.rtm = x_rtm;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check("stall",  {31'd0, stall},  {31'd0, e.stall});
        check("rsd_op", {29'd0, rsd_op}, {29'd0, e.rsd});
        check("rtd_op", {29'd0, rtd_op}, {29'd0, e.rtd});
        check("rse_op", {30'd0, rse_op}, {30'd0, e.rse});
        check("rte_op", {30'd0, rte_op}, {30'd0, e.rte});
        check("rtm_op", {31'd0, rtm_op}, {31'd0, e.rtm});
`ifdef HAZARD_STATS_EN
        check("stall_cnt", stall_cnt, exp_stall_cnt);
        check("fwd_cnt",   fwd_cnt,   exp_fwd_cnt);
`endif
        $display("txn %0d: rs=%0d rt=%0d a3=%0d rst=%0b -> stall=%0b rsd=%0d rtd=%0d rse=%0d rte=%0d rtm=%0b",
                 txn, rs, rt, a3, reset, stall, rsd_op, rtd_op, rse_op, rte_op, rtm_op);
        @(posedge clk);
`ifdef HAZARD_STATS_EN
        if (reset) begin
            exp_stall_cnt = 0;
            exp_fwd_cnt   = 0;
        end else begin
            if (e.stall) exp_stall_cnt++;
            if (e.rsd != 0 || e.rtd != 0 || e.rse != 0 || e.rte != 0 || e.rtm)
                exp_fwd_cnt++;
        end
`endif
        #1;
        txn++;
    endtask

    initial begin
        total = 0; bad = 0; txn = 0;
        reset = 1'b1;
        d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_a3 = 0; d_tnew = 0; d_src = 0;
`ifdef HAZARD_STATS_EN
        exp_stall_cnt = 0;
        exp_fwd_cnt   = 0;
`endif
        @(posedge clk); #1;
        // Reset state: everything quiet
        step(0, 0, 3, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // 1: addu $1,$2,$3 ; beq $1,$0 -> one stall, then AO_M
        step(2, 3, 1, 1, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0);

        // 2: lw $2,0($5) ; addu $3,$2,$0 -> one stall, then WD_W into E
        step(5, 2, 1, 3, 2, 2, 1,   0, 0, 0, 3, 0, 0);
        step(2, 0, 1, 1, 3, 1, 0,   1, 0, 0, 0, 0, 0);
        step(2, 0, 1, 1, 3, 1, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 3, 3, 0, 0, 0,   0, 0, 0, 3, 0, 0);

        // 3: jal ; jr $31 x3 -> PC8_E, PC8_M, WD_W
        step(0, 0, 3, 3, 31, 0, 2,  0, 0, 0, 0, 0, 0);
        step(31, 0, 0, 3, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        step(31, 0, 0, 3, 0, 0, 0,  0, 3, 0, 2, 0, 0);
        step(31, 0, 0, 3, 0, 0, 0,  0, 4, 0, 3, 0, 0);

        // 4: two writes to $5 then a reader: E ALU match blocks fall-through,
        //    then M beats W for the E-stage reader
        step(1, 1, 1, 1, 5, 1, 0,   0, 0, 0, 0, 0, 0);
        step(2, 2, 1, 1, 5, 1, 0,   0, 0, 0, 0, 0, 0);
        step(5, 0, 1, 1, 6, 1, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 3, 3, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        //    same pattern on $0: nothing ever matches
        step(1, 1, 1, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
        step(2, 2, 1, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 3, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        // 5: lw $4,0($7) ; sw $4,0($8) -> no stall, M-stage forward later
        step(7, 4, 1, 3, 4, 2, 1,   0, 0, 0, 0, 0, 0);
        step(8, 4, 1, 2, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 3, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 3, 3, 0, 0, 0,   0, 0, 0, 0, 0, 1);

        // 6: lw $9 ; beq $9,$9 -> two stalls, reset during the second
        step(0, 9, 1, 3, 9, 2, 1,   0, 0, 0, 0, 0, 0);
        step(9, 9, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(9, 9, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(9, 9, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step(9, 9, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
